// File: rtl/pulse_scheduler.sv
// Round-robin sharing of one pulse-train generator among N requesters.
// The winner's high/low/repeat fields are captured at grant time and sequenced on 'pulse'.
module pulse_scheduler #(
    parameter int N  = 4,
    parameter int CW = 8,
    parameter int RW = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] hi_len,
    input  logic [N*CW-1:0] lo_len,
    input  logic [N*RW-1:0] reps,
    output logic [N-1:0]    grant,
    output logic            pulse,
    output logic            busy,
    output logic [N-1:0]    done,
    output logic [1:0]      dbg_state_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Handshake: req[i] is a level held until done[i] strobes or the requester
    // drops it (abort); grant is the one-hot owner, done a one-cycle strobe.
    logic [1:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          pulse_q, pulse_d;
    logic          busy_q;
    logic [N-1:0]  done_q,  done_d;
    logic [PW-1:0] ptr_q,   ptr_d;
    logic [PW-1:0] win_q,   win_d;
    logic [CW-1:0] hi_q,    hi_d;
    logic [CW-1:0] lo_q,    lo_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [RW-1:0] rcnt_q,  rcnt_d;

    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] win_nxt;
    logic [PW-1:0] idx_b;
    int            idx;

    // Zero-length fields behave like one; registers hold (length - 1).
    function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [RW-1:0] rep_m1(input logic [RW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        idx_b = '0;
        for (int i = 0; i < N; i++) begin
            idx   = (int'(ptr_q) + i) % N;
            idx_b = PW'(idx);
            if (!found && req[idx_b]) begin
                found = 1'b1;
                pick  = idx_b;
            end
        end
    end

    assign win_nxt = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pulse_d = pulse_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        win_d   = win_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d       = S_HIGH;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    pulse_d       = 1'b1;
                    win_d         = pick;
                    hi_d          = len_m1(hi_len[pick*CW +: CW]);
                    lo_d          = len_m1(lo_len[pick*CW +: CW]);
                    cnt_d         = len_m1(hi_len[pick*CW +: CW]);
                    rcnt_d        = rep_m1(reps[pick*RW +: RW]);
                end
            end
            S_HIGH, S_LOW: begin
                if (!req[win_q]) begin
                    // Owner withdrew: drop the train silently and move the pointer on.
                    state_d = S_IDLE;
                    grant_d = '0;
                    pulse_d = 1'b0;
                    ptr_d   = win_nxt;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (state_q == S_HIGH) begin
                    state_d = S_LOW;
                    pulse_d = 1'b0;
                    cnt_d   = lo_q;
                end else if (rcnt_q != '0) begin
                    state_d = S_HIGH;
                    pulse_d = 1'b1;
                    cnt_d   = hi_q;
                    rcnt_d  = rcnt_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = win_nxt;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                pulse_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
            busy_q  <= |grant_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign grant       = grant_q;
    assign pulse       = pulse_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: directed table, hand-written corner sequences and a
// randomized run against a queue-based model of expected per-cycle outputs.
module tb_pulse_scheduler;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int RW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*CW-1:0] hi_len = '0;
    logic [N*CW-1:0] lo_len = '0;
    logic [N*RW-1:0] reps = '0;
    logic [N-1:0]    grant;
    logic            pulse;
    logic            busy;
    logic [N-1:0]    done;
    logic [1:0]      dbg_state;

    pulse_scheduler #(.N(N), .CW(CW), .RW(RW)) dut (
        .clock(clock), .reset(reset), .req(req),
        .hi_len(hi_len), .lo_len(lo_len), .reps(reps),
        .grant(grant), .pulse(pulse), .busy(busy), .done(done),
        .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_all(input int h, input int l, input int r);
        for (int i = 0; i < N; i++) begin
            hi_len[i*CW +: CW] = CW'(h);
            lo_len[i*CW +: CW] = CW'(l);
            reps[i*RW +: RW]   = RW'(r);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Runs one train from idle; stops at the first idle sample after the grant.
    task automatic run_train(input logic [N-1:0] mask, output logic [N-1:0] first_g,
                             output int len, output int highs,
                             output logic [N-1:0] done_v, output int done_at,
                             output int busy_err);
        req = mask; first_g = '0; len = 0; highs = 0; done_v = '0; done_at = 0; busy_err = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (busy !== (grant != '0)) busy_err++;
            if (grant != '0) begin
                if (len == 0) first_g = grant;
                len++;
                if (pulse) highs++;
                if (done != '0) begin
                    done_v  = done;
                    done_at = len;
                end
            end else if (len > 0) begin
                break;
            end
        end
        req = '0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           h;
        int           l;
        int           r;
        logic [N-1:0] exp_grant;
        int           exp_len;
        int           exp_highs;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] g;
        logic         p;
        logic [N-1:0] d;
    } out_t;

    out_t exp_q[$];

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    initial begin
        vec_t         vecs[7];
        logic [N-1:0] fg, dv, g;
        int           len, highs, dat, berr, idle, mptr;
        logic [11:0]  pv;
        logic [N-1:0] other_done;
        out_t         cur_exp, e;

        vecs[0] = '{4'b0001, 3,   2, 2,  4'b0001, 11,  6};
        vecs[1] = '{4'b0100, 0,   0, 0,  4'b0100, 3,   1};
        vecs[2] = '{4'b1010, 1,   1, 1,  4'b0010, 3,   1};
        vecs[3] = '{4'b1000, 2,   5, 3,  4'b1000, 22,  6};
        vecs[4] = '{4'b1100, 4,   1, 0,  4'b0100, 6,   4};
        vecs[5] = '{4'b0110, 255, 0, 1,  4'b0010, 257, 255};
        vecs[6] = '{4'b0001, 1,   1, 15, 4'b0001, 31,  15};

        do_reset();
        check("reset_grant", grant, 0);
        check("reset_pulse", pulse, 0);
        check("reset_busy",  busy,  0);
        check("reset_done",  done,  0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            set_all(vecs[v].h, vecs[v].l, vecs[v].r);
            run_train(vecs[v].req, fg, len, highs, dv, dat, berr);
            check($sformatf("vec%0d_grant", v), fg, vecs[v].exp_grant);
            check($sformatf("vec%0d_len", v), len, vecs[v].exp_len);
            check($sformatf("vec%0d_highs", v), highs, vecs[v].exp_highs);
            check($sformatf("vec%0d_done", v), dv, vecs[v].exp_grant);
            check($sformatf("vec%0d_done_at", v), dat, vecs[v].exp_len);
            check($sformatf("vec%0d_busy", v), berr, 0);
        end

        // Exact waveform of a 3-high/2-low, 2-repeat train.
        do_reset();
        set_all(3, 2, 2);
        req = 4'b0001; pv = '0; other_done = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            pv = {pv[10:0], pulse};
            if (c == 11) check("t2_done11", done, 4'b0001);
            else other_done |= done;
            if (c == 12) check("t2_grant12", grant, 0);
        end
        check("t2_pulse_wave", pv, 12'b111001110000);
        check("t2_no_extra_done", other_done, 0);
        req = '0;

        // Fields changed mid-train must not affect the running train.
        do_reset();
        set_all(4, 1, 2);
        req = 4'b0001; pv = '0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clock);
            if (c == 1) set_all(1, 1, 2);
            if (c <= 10) pv = {pv[10:0], pulse};
            if (c == 11) check("t6_done11", done, 4'b0001);
        end
        check("t6_pulse_wave", pv, 12'b001111011110);
        req = '0;

        // Fairness with all requests held and unit fields.
        do_reset();
        set_all(1, 1, 1);
        req = '1;
        for (int k = 0; k < 5; k++) begin
            int c;
            c = 0; idle = 0; len = 0;
            while (grant == '0 && c < 50) begin idle++; c++; @(negedge clock); end
            g = grant;
            while (grant == g && c < 50) begin len++; c++; @(negedge clock); end
            check($sformatf("t3_grant%0d", k), g, 1 << (k % N));
            check($sformatf("t3_len%0d", k), len, 3);
            check($sformatf("t3_idle%0d", k), idle, 1);
        end
        req = '0;

        // Asynchronous reset in the middle of a HIGH phase, with pointer moved off 0.
        do_reset();
        set_all(2, 2, 1);
        run_train(4'b0010, fg, len, highs, dv, dat, berr);
        req = 4'b0100;
        @(negedge clock);
        check("t1_pre_grant", grant, 4'b0100);
        #2 reset = 1'b0;
        #1;
        check("t1_grant", grant, 0);
        check("t1_pulse", pulse, 0);
        check("t1_busy",  busy,  0);
        check("t1_done",  done,  0);
        check("t1_state", dbg_state, 0);
        @(negedge clock);
        reset = 1'b1;
        set_all(1, 1, 1);
        req = '1;
        @(negedge clock);
        check("t1_ptr0_grant", grant, 4'b0001);
        req = '0;
        repeat (4) @(negedge clock);

        // Abort during HIGH: no done, pointer advances past the aborted owner.
        do_reset();
        set_all(5, 1, 1);
        req = 4'b0010;
        @(negedge clock);
        check("t5_grant", grant, 4'b0010);
        @(negedge clock);
        req = 4'b0101;
        @(negedge clock);
        check("t5_abort", {grant, pulse, done}, 0);
        @(negedge clock);
        check("t5_next_grant", grant, 4'b0100);
        req = '0;

        // Randomized run against a queue of expected per-cycle outputs.
        do_reset();
        exp_q.delete();
        mptr = 0;
        cur_exp = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            check("rand_outputs", {grant, pulse, done}, cur_exp);
            if (exp_q.size() == 0) req = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                hi_len[i*CW +: CW] = CW'($urandom_range(0, 3));
                lo_len[i*CW +: CW] = CW'($urandom_range(0, 3));
                reps[i*RW +: RW]   = RW'($urandom_range(0, 3));
            end
            if (exp_q.size() == 0 && req != '0) begin
                int w, h, l, r;
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(mptr + k) % N]) w = (mptr + k) % N;
                h = eff(int'(hi_len[w*CW +: CW]));
                l = eff(int'(lo_len[w*CW +: CW]));
                r = eff(int'(reps[w*RW +: RW]));
                g = '0;
                g[w] = 1'b1;
                for (int p = 0; p < r; p++) begin
                    for (int t = 0; t < h; t++) begin e = '{g, 1'b1, '0}; exp_q.push_back(e); end
                    for (int t = 0; t < l; t++) begin e = '{g, 1'b0, '0}; exp_q.push_back(e); end
                end
                e = '{g, 1'b0, g}; exp_q.push_back(e);
                e = '0; exp_q.push_back(e);
                mptr = (w + 1) % N;
            end
            cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            @(negedge clock);
        end
        req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
